if_loop_acc: RTL
================

# if_loop_acc

Parametrised successor to the single-channel conditional-loop component. It streams `n` elements from memory starting at base address `a` over a pipelined Avalon-MM read master. Each element is filtered against a runtime threshold under a selectable mode, and the filtered terms are accumulated. The result is returned through the standard component call/return handshake, so it drops into the same HLS component wrapper as the existing loop kernels.

## Interface
Parameters:
- `DATA_W`, 32: element and accumulator width; multiple of 8.
- `ADDR_W`, 64: byte address width.
- `CNT_W`, 32: width of `n`.
- `MAX_OUTSTANDING`, 4: maximum reads in flight; ≥1.

Ports:
- `clock` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: call.valid.
- `busy` out 1: call.stall.
- `done` out 1: return.valid.
- `stall` in 1: return.stall.
- `returndata` out DATA_W: return.data.
- `a` in ADDR_W: base byte address; sampled at call.
- `n` in CNT_W: element count, unsigned; sampled at call.
- `thr` in DATA_W: signed threshold; sampled at call.
- `mode` in 2: filter mode; sampled at call.
- `avm_address` out ADDR_W: read byte address.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave back-pressure.
- `avm_readdata` in DATA_W: read data.
- `avm_readdatavalid` in 1: read data valid; responses return in order.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start && !busy`.
  - RUN → DRAIN when issued == n.
  - DRAIN → DONE when received == n.
  - DONE → IDLE on `done && !stall`.
- Call acceptance: a call is accepted when `start` is high in IDLE. `a`, `n`, `thr`, `mode` are latched on acceptance. Accumulator, issued count and received count are cleared.
- `n == 0`: IDLE → DONE directly. `returndata = 0`. No reads are issued.
- Read address: element i is read at `a + i*(DATA_W/8)`, modulo 2^ADDR_W.
- Read issue: `avm_read` asserts in RUN while issued < n and outstanding < MAX_OUTSTANDING.
  - The request holds address and `avm_read` stable while `avm_waitrequest` is high.
  - issued increments on `avm_read && !avm_waitrequest`.
- Outstanding count: +1 on an accepted read, −1 on `avm_readdatavalid`. Both in the same cycle leave it unchanged.
- Filter and accumulate, per element x (signed DATA_W), applied on each `avm_readdatavalid` in RUN or DRAIN:
  - mode 0: acc += x if x > thr.
  - mode 1: acc += x if x ≤ thr.
  - mode 2: acc += 1 if x > thr.
  - mode 3: acc += x unconditionally.
- Arithmetic: accumulation wraps modulo 2^DATA_W, with no saturation.
- `readdatavalid` in IDLE or DONE is ignored and is not an error.
- Return: in DONE, `done = 1` and `returndata = acc`, held stable until `stall` is low.
- `busy = 1` in every state except IDLE. `start` while busy is not accepted, and the caller holds it.

## Timing
- Reset values: `busy = 0`, `done = 0`, `returndata = 0`, `avm_read = 0`, `avm_address = 0`. FSM state is IDLE.
- Acceptance at cycle T: `busy` goes high at T+1, and the first `avm_read` is at T+1.
- Throughput: with no wait states and read latency L ≤ MAX_OUTSTANDING−1, one read issues per cycle.
- Latency: `done` rises the cycle after the last `readdatavalid`. For `n == 0`, `done` rises at T+1.
- Back-to-back calls: a new `start` can be accepted the cycle after the return transfer (one cycle in IDLE).
- Reset mid-operation: returns immediately to reset values and drops the in-flight count. Late responses arriving afterwards are ignored by the IDLE rule.

## Structure
- Package `if_loop_pkg`:
  - state enum.
  - mode constants `MODE_GT`, `MODE_LE`, `MODE_CNT`, `MODE_ALL`.
  - `clog2` helper for the outstanding counter width, clog2(MAX_OUTSTANDING+1).
- Sub-module `if_loop_filter_acc`:
  - Inputs: x, thr, mode, valid, clear.
  - Contains the signed compare and the accumulator register.
  - The top level holds the FSM, address generator, issue/receive counters and the handshake logic.

## Test plan
- Basic mode 0: a=0x1000, n=4, data {5, −3, 10, 0}, thr=0, zero-wait memory L=2. Required: addresses 0x1000, 0x1004, 0x1008, 0x100C; returndata=15; done one cycle after the 4th valid.
- `n == 0`: done at T+1 with returndata=0; `avm_read` never asserts.
- Back-pressure: `avm_waitrequest` high for 3 cycles on element 1, and L=6 with MAX_OUTSTANDING=4. Required: address held stable during the wait; outstanding never exceeds 4; mode 3 sum correct.
- Modes 1 and 2: data {1, 2, 3, 4}, thr=2. Required: mode 1 returns 3; mode 2 returns 2.
- Wrap:
  - data {0x7FFFFFFF, 1}, mode 3. Required: returndata 0x80000000.
  - Address wrap with a = 2^64−4, n=2. Required: second address is 0.
- Return stall and reset mid-run:
  - stall held high for 5 cycles in DONE. Required: returndata stable; `busy` stays high.
  - Reset asserted during RUN with 2 reads in flight. Required: all outputs return to 0; the next call returns the correct sum.

Source files
------------

// File: rtl/if_loop_pkg.sv
// Shared types and constants for the conditional-loop accumulator.
package if_loop_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_GT  = 2'd0;  // add x when x >  thr
   localparam logic [1:0] MODE_LE  = 2'd1;  // add x when x <= thr
   localparam logic [1:0] MODE_CNT = 2'd2;  // add 1 when x >  thr
   localparam logic [1:0] MODE_ALL = 2'd3;  // add x always

   // Ceiling log2, used to size counters that must hold the value itself.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/if_loop_filter_acc.sv
// Per-element threshold filter feeding a wrapping signed accumulator.
module if_loop_filter_acc
   import if_loop_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] thr,
   input  logic [1:0]               mode,
   input  logic                     valid,
   input  logic                     clear,
   output logic signed [DATA_W-1:0] acc
);

   // Term contributed by one element; zero when the element is filtered out.
   function automatic logic signed [DATA_W-1:0] filter_term(
      input logic signed [DATA_W-1:0] xv,
      input logic signed [DATA_W-1:0] tv,
      input logic [1:0]               mv
   );
      logic signed [DATA_W-1:0] term;
      term = '0;
      case (mv)
         MODE_GT:  term = (xv >  tv) ? xv : '0;
         MODE_LE:  term = (xv <= tv) ? xv : '0;
         MODE_CNT: term = (xv >  tv) ? DATA_W'(1) : '0;
         default:  term = xv;
      endcase
      return term;
   endfunction

   // Accumulate filtered terms; the sum wraps modulo 2^DATA_W on purpose.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (valid) begin
         acc <= acc + filter_term(x, thr, mode);
      end
   end

endmodule

// File: rtl/if_loop_acc.sv
// Streams n elements over a pipelined Avalon-MM read master, filters each
// against a threshold and returns the accumulated sum via call/return.
module if_loop_acc
   import if_loop_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 64,
   parameter int CNT_W           = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              stall,
   output logic [DATA_W-1:0] returndata,
   input  logic [ADDR_W-1:0] a,
   input  logic [CNT_W-1:0]  n,
   input  logic [DATA_W-1:0] thr,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid
);

   localparam int               OS_W   = clog2(MAX_OUTSTANDING + 1);
   localparam logic [OS_W-1:0]  OS_MAX = OS_W'(MAX_OUTSTANDING);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

   state_t                   state;
   logic [ADDR_W-1:0]        addr;
   logic [CNT_W-1:0]         n_r;
   logic [CNT_W-1:0]         issued;
   logic [CNT_W-1:0]         received;
   logic [CNT_W-1:0]         issued_nxt;
   logic [CNT_W-1:0]         received_nxt;
   logic signed [DATA_W-1:0] thr_r;
   logic [1:0]               mode_r;
   logic [OS_W-1:0]          outstanding;
   logic                     done_r;
   logic                     accept_call;
   logic                     rd_accept;
   logic                     rd_take;
   logic signed [DATA_W-1:0] acc;

   assign accept_call = start && (state == ST_IDLE);
   assign avm_read    = (state == ST_RUN) && (issued < n_r) && (outstanding < OS_MAX);
   assign rd_accept   = avm_read && !avm_waitrequest;
   // Responses outside RUN/DRAIN belong to an aborted call and are dropped.
   assign rd_take     = avm_readdatavalid && ((state == ST_RUN) || (state == ST_DRAIN));

   assign issued_nxt   = issued + CNT_W'(rd_accept);
   assign received_nxt = received + CNT_W'(rd_take);

   assign avm_address = addr;
   assign busy        = (state != ST_IDLE);
   assign done        = done_r;
   assign returndata  = acc;

   // Call arguments are only meaningful once a call is accepted.
   always_ff @(posedge clock) begin
      if (accept_call) begin
         n_r    <= n;
         thr_r  <= signed'(thr);
         mode_r <= mode;
      end
   end

   // Control FSM: issue reads, wait for the tail responses, hold the return.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         addr     <= '0;
         issued   <= '0;
         received <= '0;
         done_r   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr     <= a;
                  issued   <= '0;
                  received <= '0;
                  if (n == '0) begin
                     state  <= ST_DONE;
                     done_r <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (rd_accept) begin
                  addr <= addr + STRIDE;
               end
               issued   <= issued_nxt;
               received <= received_nxt;
               // The last response always lands at least a cycle after its issue.
               if (issued_nxt == n_r) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               received <= received_nxt;
               // Look ahead so done rises the cycle after the final response.
               if (received_nxt == n_r) begin
                  state  <= ST_DONE;
                  done_r <= 1'b1;
               end
            end
            default: begin
               if (!stall) begin
                  state  <= ST_IDLE;
                  done_r <= 1'b0;
               end
            end
         endcase
      end
   end

   // Reads in flight; issue and response in one cycle cancel out.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         outstanding <= '0;
      end else if (accept_call) begin
         outstanding <= '0;
      end else if (rd_accept && !rd_take) begin
         outstanding <= outstanding + OS_W'(1);
      end else if (!rd_accept && rd_take && (outstanding != '0)) begin
         outstanding <= outstanding - OS_W'(1);
      end
   end

   if_loop_filter_acc #(
      .DATA_W (DATA_W)
   ) u_filter_acc (
      .clock  (clock),
      .resetn (resetn),
      .x      (signed'(avm_readdata)),
      .thr    (thr_r),
      .mode   (mode_r),
      .valid  (rd_take),
      .clear  (accept_call),
      .acc    (acc)
   );

endmodule
